writeback_stage: RTL and testbench

Final (WB) stage of the 5-stage pipeline, directly upstream of `register_file`. It holds the MEM/WB pipeline register and selects between the ALU result and the aligned, sign- or zero-extended load data. It drives the register file write port (`Write_addr`, `Write_En`, `Write_data`). Because register file reads are asynchronous and writes land on the clock edge, it also provides a same-cycle WB→ID bypass on both read ports and counts retired instructions.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/load_align.sv | 34 +++
 rtl/writeback_stage.sv | 96 +++++++++
 tb/tb_writeback_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared between the MEM-stage decoder and the writeback stage.
package cpu_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Any code outside the defined sub-word loads behaves as a full word load.
  function automatic logic lt_is_word(input logic [2:0] lt);
    return !(lt == LT_LB || lt == LT_LH || lt == LT_LBU || lt == LT_LHU);
  endfunction

  function automatic logic lt_is_half(input logic [2:0] lt);
    return (lt == LT_LH || lt == LT_LHU);
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian extraction and sign/zero extension of load data from a word read.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] data
);

  logic [4:0]  byte_lo;
  logic [4:0]  half_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_lo  = {off, 3'b000};
  assign half_lo  = {off[1], 4'b0000};
  assign byte_sel = read_data[byte_lo +: 8];
  assign half_sel = read_data[half_lo +: 16];

  always_comb begin
    data = read_data;
    case (load_type)
      LT_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = read_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// WB stage: MEM/WB register, result select, register-file write port,
// same-cycle WB->ID bypass and retired-instruction counter.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Mem_valid,
  input  logic [ADDR_W-1:0] Mem_rd,
  input  logic              Mem_reg_write,
  input  logic              Mem_mem_to_reg,
  input  logic [2:0]        Mem_load_type,
  input  logic [DATA_W-1:0] Mem_alu_result,
  input  logic [DATA_W-1:0] Mem_read_data,
  input  logic [ADDR_W-1:0] Id_addr1,
  input  logic [ADDR_W-1:0] Id_addr2,
  input  logic [DATA_W-1:0] Rf_data1,
  input  logic [DATA_W-1:0] Rf_data2,
  output logic [DATA_W-1:0] Id_data1,
  output logic [DATA_W-1:0] Id_data2,
  output logic [ADDR_W-1:0] Write_addr,
  output logic              Write_En,
  output logic [DATA_W-1:0] Write_data,
  output logic              Misaligned,
  output logic [31:0]       Retire_count
);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic [2:0]        wb_load_type;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_read_data;
  logic [31:0]       retire_q;
  logic [DATA_W-1:0] load_data;
  logic [1:0]        off;

  // Reset clears everything; a flush only needs to kill valid.
  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_load_type  <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
    end else if (Flush) begin
      wb_valid      <= 1'b0;
    end else if (!Stall) begin
      wb_valid      <= Mem_valid;
      wb_rd         <= Mem_rd;
      wb_reg_write  <= Mem_reg_write;
      wb_mem_to_reg <= Mem_mem_to_reg;
      wb_load_type  <= Mem_load_type;
      wb_alu_result <= Mem_alu_result;
      wb_read_data  <= Mem_read_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_n)
      retire_q <= '0;
    else if (wb_valid && !Stall)
      retire_q <= retire_q + 32'd1;
  end

  assign off = wb_alu_result[1:0];

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .load_type (wb_load_type),
    .off       (off),
    .read_data (wb_read_data),
    .data      (load_data)
  );

  assign Write_En     = wb_valid && wb_reg_write && (wb_rd != '0) && !Stall;
  assign Write_addr   = wb_rd;
  assign Write_data   = wb_mem_to_reg ? load_data : wb_alu_result;
  assign Retire_count = retire_q;

  assign Misaligned = wb_valid && wb_mem_to_reg && !Stall &&
                      ((lt_is_word(wb_load_type) && (off != 2'b00)) ||
                       (lt_is_half(wb_load_type) && off[0]));

  // Register file writes land on the edge, so ID must see the in-flight value now.
  assign Id_data1 = (Write_En && (Write_addr == Id_addr1)) ? Write_data : Rf_data1;
  assign Id_data2 = (Write_En && (Write_addr == Id_addr2)) ? Write_data : Rf_data2;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;
  import cpu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n, Stall, Flush;
  logic        Mem_valid, Mem_reg_write, Mem_mem_to_reg;
  logic [4:0]  Mem_rd, Id_addr1, Id_addr2, Write_addr;
  logic [2:0]  Mem_load_type;
  logic [31:0] Mem_alu_result, Mem_read_data, Rf_data1, Rf_data2;
  logic [31:0] Id_data1, Id_data2, Write_data, Retire_count;
  logic        Write_En, Misaligned;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 Clock = ~Clock;

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
    .Mem_valid(Mem_valid), .Mem_rd(Mem_rd), .Mem_reg_write(Mem_reg_write),
    .Mem_mem_to_reg(Mem_mem_to_reg), .Mem_load_type(Mem_load_type),
    .Mem_alu_result(Mem_alu_result), .Mem_read_data(Mem_read_data),
    .Id_addr1(Id_addr1), .Id_addr2(Id_addr2), .Rf_data1(Rf_data1), .Rf_data2(Rf_data2),
    .Id_data1(Id_data1), .Id_data2(Id_data2), .Write_addr(Write_addr),
    .Write_En(Write_En), .Write_data(Write_data), .Misaligned(Misaligned),
    .Retire_count(Retire_count)
  );

  // Presents one instruction, lets it load on the next edge, then idles MEM.
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic rw,
                               input logic m2r, input logic [2:0] lt,
                               input logic [31:0] alu, input logic [31:0] rdata);
    @(negedge Clock);
    Mem_valid = v; Mem_rd = rd; Mem_reg_write = rw; Mem_mem_to_reg = m2r;
    Mem_load_type = lt; Mem_alu_result = alu; Mem_read_data = rdata;
    @(posedge Clock); #1;
    Mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    Mem_valid = 1'b0; Mem_rd = '0; Mem_reg_write = 1'b0; Mem_mem_to_reg = 1'b0;
    Mem_load_type = LT_LW; Mem_alu_result = '0; Mem_read_data = '0;
    Id_addr1 = 5'd3; Id_addr2 = 5'd4; Rf_data1 = 32'h11; Rf_data2 = 32'h22;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %0b want 0", Write_En); end
    n_checks++; if (Write_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0d want 0", Write_addr); end
    n_checks++; if (Write_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", Write_data); end
    n_checks++; if (Misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mis: got %0b want 0", Misaligned); end
    n_checks++; if (Retire_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", Retire_count); end
    n_checks++; if (Id_data1 !== 32'h11) begin n_fail++; $display("[TB] FAIL reset_id1: got %h want 11", Id_data1); end
    n_checks++; if (Id_data2 !== 32'h22) begin n_fail++; $display("[TB] FAIL reset_id2: got %h want 22", Id_data2); end
    @(negedge Clock);
    Reset_n = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_alu_writeback();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, LT_LW, 32'h1234_5678, 32'h0);
    n_checks++; if (Write_En !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_we: got %0b want 1", Write_En); end
    n_checks++; if (Write_addr !== 5'd5) begin n_fail++; $display("[TB] FAIL alu_addr: got %0d want 5", Write_addr); end
    n_checks++; if (Write_data !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL alu_data: got %h want 12345678", Write_data); end
    @(posedge Clock); #1;
    exp_count = 1;
    n_checks++; if (Retire_count !== 32'd1) begin n_fail++; $display("[TB] FAIL alu_count: got %0d want 1", Retire_count); end
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_once: got %0b want 0", Write_En); end
  endtask

  task automatic test_load_align();
    logic [2:0]  lts  [5] = '{LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, lts[i], {30'h400, offs[i]}, 32'h80FF_7F01);
      exp_count++;
      n_checks++; if (Write_data !== exps[i]) begin n_fail++; $display("[TB] FAIL load_data[%0d]: got %h want %h", i, Write_data, exps[i]); end
      n_checks++; if (Misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL load_mis[%0d]: got %0b want 0", i, Misaligned); end
    end
  endtask

  task automatic test_bypass();
    Id_addr1 = 5'd7; Id_addr2 = 5'd8; Rf_data1 = 32'h1; Rf_data2 = 32'h2;
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, LT_LW, 32'hAAAA_0000, 32'h0);
    exp_count++;
    n_checks++; if (Id_data1 !== 32'hAAAA_0000) begin n_fail++; $display("[TB] FAIL byp_id1: got %h want aaaa0000", Id_data1); end
    n_checks++; if (Id_data2 !== 32'h2) begin n_fail++; $display("[TB] FAIL byp_id2: got %h want 2", Id_data2); end
    Id_addr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, LT_LW, 32'hBBBB_0000, 32'h0);
    exp_count++;
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL byp_r0_we: got %0b want 0", Write_En); end
    n_checks++; if (Id_data1 !== 32'h1) begin n_fail++; $display("[TB] FAIL byp_r0_id1: got %h want 1", Id_data1); end
  endtask

  task automatic test_stall_flush();
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b0, LT_LW, 32'h55, 32'h0);
    Stall = 1'b1; #1;
    n_checks++; if (Write_en_or(Write_En) !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_we0: got %0b want 0", Write_En); end
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_we[%0d]: got %0b want 0", i, Write_En); end
      n_checks++; if (Retire_count !== exp_count) begin n_fail++; $display("[TB] FAIL stall_count[%0d]: got %0d want %0d", i, Retire_count, exp_count); end
    end
    @(negedge Clock);
    Stall = 1'b0; #1;
    n_checks++; if (Write_En !== 1'b1) begin n_fail++; $display("[TB] FAIL unstall_we: got %0b want 1", Write_En); end
    n_checks++; if (Write_data !== 32'h55) begin n_fail++; $display("[TB] FAIL unstall_data: got %h want 55", Write_data); end
    @(posedge Clock); #1;
    exp_count++;
    n_checks++; if (Retire_count !== exp_count) begin n_fail++; $display("[TB] FAIL unstall_count: got %0d want %0d", Retire_count, exp_count); end
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL unstall_once: got %0b want 0", Write_En); end
    applyStimulus(1'b1, 5'd13, 1'b1, 1'b0, LT_LW, 32'h66, 32'h0);
    Stall = 1'b1; Flush = 1'b1;
    @(posedge Clock); #1;
    Stall = 1'b0; Flush = 1'b0; #1;
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_we: got %0b want 0", Write_En); end
    @(posedge Clock); #1;
    n_checks++; if (Retire_count !== exp_count) begin n_fail++; $display("[TB] FAIL flush_count: got %0d want %0d", Retire_count, exp_count); end
  endtask

  function automatic logic Write_en_or(input logic we);
    return we;
  endfunction

  task automatic test_misaligned();
    applyStimulus(1'b1, 5'd14, 1'b1, 1'b1, LT_LW, 32'h1002, 32'hDEAD_BEEF);
    exp_count++;
    n_checks++; if (Misaligned !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_lw: got %0b want 1", Misaligned); end
    n_checks++; if (Write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL mis_lw_data: got %h want deadbeef", Write_data); end
    n_checks++; if (Write_En !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_lw_we: got %0b want 1", Write_En); end
    applyStimulus(1'b1, 5'd15, 1'b1, 1'b1, LT_LH, 32'h1001, 32'h80FF_7F01);
    exp_count++;
    n_checks++; if (Misaligned !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_lh: got %0b want 1", Misaligned); end
    n_checks++; if (Write_data !== 32'h0000_7F01) begin n_fail++; $display("[TB] FAIL mis_lh_data: got %h want 00007f01", Write_data); end
    @(posedge Clock); #1;
    n_checks++; if (Misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_clear: got %0b want 0", Misaligned); end
    n_checks++; if (Retire_count !== exp_count) begin n_fail++; $display("[TB] FAIL mis_count: got %0d want %0d", Retire_count, exp_count); end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 5'd16, 1'b1, 1'b0, LT_LW, 32'h77, 32'h0);
    Stall = 1'b1;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    Stall = 1'b0; #1;
    exp_count = 0;
    n_checks++; if (Write_En !== 1'b0) begin n_fail++; $display("[TB] FAIL rststall_we: got %0b want 0", Write_En); end
    n_checks++; if (Retire_count !== 32'd0) begin n_fail++; $display("[TB] FAIL rststall_count: got %0d want 0", Retire_count); end
    @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock); #1;
    n_checks++; if (Retire_count !== 32'd0) begin n_fail++; $display("[TB] FAIL rststall_count2: got %0d want 0", Retire_count); end
  endtask

  task automatic test_counter_wrap();
    @(negedge Clock);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, LT_LW, 32'h0, 32'h0);
    n_checks++; if (Retire_count !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL wrap_pre: got %h want ffffffff", Retire_count); end
    @(posedge Clock); #1;
    n_checks++; if (Retire_count !== 32'd0) begin n_fail++; $display("[TB] FAIL wrap: got %h want 0", Retire_count); end
  endtask

  initial begin
    test_reset();
    test_alu_writeback();
    test_load_align();
    test_bypass();
    test_stall_flush();
    test_misaligned();
    test_reset_mid_stall();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
